car_line_ctrl: RTL and testbench

Parametrised line-following motor controller for the car platform. Inputs are two IR line sensors (`infL`, `infR`). Each sensor is synchronised and debounced, then a direction state machine runs, and PWM-modulated drive is produced on the four H-bridge inputs `md1`–`md4`. It adds three things to the fixed-level steering decode: speed control, a pivot/swing turn mode, and a lost-line back-off recovery sequence.

---
 rtl/car_line_ctrl_if.sv | 29 ++
 rtl/car_line_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_car_line_ctrl.sv | 392 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/car_line_ctrl_if.sv
// Signal bundle between the line-following controller and its surroundings.
// Sensor inputs, drive controls and the H-bridge / debug outputs are grouped here.
//   master: environment side (drives sensors, run, pivot, speeds; observes md*, state)
//   slave : controller side (observes sensors and controls; drives md*, state)
interface car_line_ctrl_if #(
    parameter int unsigned PWM_W = 8
) ();
    logic             infL;
    logic             infR;
    logic             run;
    logic             pivot;
    logic [PWM_W-1:0] speed_fwd;
    logic [PWM_W-1:0] speed_turn;
    logic             md1;
    logic             md2;
    logic             md3;
    logic             md4;
    logic [2:0]       state;

    modport master (
        output infL, infR, run, pivot, speed_fwd, speed_turn,
        input  md1, md2, md3, md4, state
    );

    modport slave (
        input  infL, infR, run, pivot, speed_fwd, speed_turn,
        output md1, md2, md3, md4, state
    );
endinterface

// File: rtl/car_line_ctrl.sv
// Line-following motor controller.
// Two asynchronous IR sensors are synchronised and debounced, a direction FSM picks
// FWD/LEFT/RIGHT/STOP from the filtered pair, a long STOP triggers a timed BACK
// recovery, and PWM drive is produced on the four H-bridge inputs.
// Ports:
//   clk     : system clock
//   reset_n : synchronous active-low reset
//   bus     : car_line_ctrl_if.slave (infL/infR sensors, run, pivot, speed_fwd,
//             speed_turn in; md1..md4 drive and 3-bit debug state out)
module car_line_ctrl #(
    parameter int unsigned PWM_W    = 8,
    parameter int unsigned FILT     = 3,
    parameter int unsigned HOLD_CYC = 1024,
    parameter int unsigned BACK_CYC = 256
) (
    input logic            clk,
    input logic            reset_n,
    car_line_ctrl_if.slave bus
);

    localparam int unsigned FCW  = $clog2(FILT + 1);
    localparam int unsigned TMAX = (HOLD_CYC > BACK_CYC) ? HOLD_CYC : BACK_CYC;
    localparam int unsigned TW   = $clog2(TMAX + 1);

    localparam logic [FCW-1:0] FiltLast = FCW'(FILT - 1);
    localparam logic [TW-1:0]  HoldLast = TW'(HOLD_CYC - 1);
    localparam logic [TW-1:0]  BackLast = TW'(BACK_CYC - 1);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StFwd   = 3'd1,
        StLeft  = 3'd2,
        StRight = 3'd3,
        StStop  = 3'd4,
        StBack  = 3'd5
    } state_e;

    // Sensor path: bit 1 = left, bit 0 = right.
    logic [1:0]     pin;
    logic [1:0]     sync1_q;
    logic [1:0]     sync2_q;
    logic [1:0]     filt_q;
    logic [FCW-1:0] fcnt_q [2];

    assign pin = {bus.infL, bus.infR};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            filt_q    <= '0;
            fcnt_q[0] <= '0;
            fcnt_q[1] <= '0;
        end else begin
            sync1_q <= pin;
            sync2_q <= sync1_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == filt_q[i]) begin
                    fcnt_q[i] <= '0;
                end else if (fcnt_q[i] == FiltLast) begin
                    // FILT-th consecutive mismatch: accept the new level.
                    filt_q[i] <= sync2_q[i];
                    fcnt_q[i] <= '0;
                end else begin
                    fcnt_q[i] <= fcnt_q[i] + 1'b1;
                end
            end
        end
    end

    state_e decision;

    always_comb begin
        decision = StStop;
        case (filt_q)
            2'b00:   decision = StFwd;
            2'b10:   decision = StLeft;
            2'b01:   decision = StRight;
            default: decision = StStop;
        endcase
    end

    // Direction FSM: state register.
    state_e        state_q;
    state_e        state_d;
    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    // Direction FSM: next state. The timer is shared by the STOP hold and BACK phases.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        if (!bus.run) begin
            state_d = StIdle;
            timer_d = '0;
        end else begin
            case (state_q)
                StIdle, StFwd, StLeft, StRight: begin
                    state_d = decision;
                    timer_d = '0;
                end
                StStop: begin
                    if (filt_q == 2'b11) begin
                        if (timer_q == HoldLast) begin
                            state_d = StBack;
                            timer_d = '0;
                        end else begin
                            timer_d = timer_q + 1'b1;
                        end
                    end else begin
                        state_d = decision;
                        timer_d = '0;
                    end
                end
                StBack: begin
                    // Sensors are ignored until the back-off completes.
                    if (timer_q == BackLast) begin
                        state_d = decision;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                default: begin
                    state_d = StIdle;
                    timer_d = '0;
                end
            endcase
        end
    end

    // PWM: duties only reload at the end of a period so a change never splits a period.
    logic [PWM_W-1:0] cnt_q;
    logic [PWM_W-1:0] dfwd_q;
    logic [PWM_W-1:0] dturn_q;
    logic             pwm_f;
    logic             pwm_t;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            dfwd_q  <= '0;
            dturn_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
            if (&cnt_q) begin
                dfwd_q  <= bus.speed_fwd;
                dturn_q <= bus.speed_turn;
            end
        end
    end

    assign pwm_f = (cnt_q < dfwd_q);
    assign pwm_t = (cnt_q < dturn_q);

    // Direction FSM: outputs. Each state drives at most one leg per motor.
    logic md1_d, md2_d, md3_d, md4_d;
    logic md1_q, md2_q, md3_q, md4_q;

    always_comb begin
        md1_d = 1'b0;
        md2_d = 1'b0;
        md3_d = 1'b0;
        md4_d = 1'b0;
        case (state_q)
            StFwd: begin
                md1_d = pwm_f;
                md3_d = pwm_f;
            end
            StLeft: begin
                md3_d = pwm_t;
                md2_d = pwm_t & bus.pivot;
            end
            StRight: begin
                md1_d = pwm_t;
                md4_d = pwm_t & bus.pivot;
            end
            StBack: begin
                md2_d = pwm_t;
                md4_d = pwm_t;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            md1_q <= 1'b0;
            md2_q <= 1'b0;
            md3_q <= 1'b0;
            md4_q <= 1'b0;
        end else begin
            md1_q <= md1_d;
            md2_q <= md2_d;
            md3_q <= md3_d;
            md4_q <= md4_d;
        end
    end

    assign bus.md1   = md1_q;
    assign bus.md2   = md2_q;
    assign bus.md3   = md3_q;
    assign bus.md4   = md4_q;
    assign bus.state = state_q;

endmodule

// File: tb/tb_car_line_ctrl.sv
// Self-checking bench for car_line_ctrl (PWM_W=4, FILT=3, HOLD_CYC=8, BACK_CYC=4).
module tb_car_line_ctrl;

    localparam int PW   = 4;
    localparam int FL   = 3;
    localparam int HOLD = 8;
    localparam int BACK = 4;
    localparam int PER  = 1 << PW;

    logic clk;
    logic reset_n;

    car_line_ctrl_if #(.PWM_W(PW)) bus ();

    car_line_ctrl #(
        .PWM_W   (PW),
        .FILT    (FL),
        .HOLD_CYC(HOLD),
        .BACK_CYC(BACK)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    function automatic void check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Reference model: behaviour stated in terms of sample history, dwell times and
    // period position rather than registers.
    bit   hist_l[$];
    bit   hist_r[$];
    bit   m_fl, m_fr;
    int   m_strk_l, m_strk_r;
    int   m_state;
    int   m_dwell;
    int   m_cnt;
    int   m_dfwd, m_dturn;
    logic [3:0] m_md;

    function automatic int decide(input bit l, input bit r);
        if (!l && !r) return 1;
        if (l && !r)  return 2;
        if (!l && r)  return 3;
        return 4;
    endfunction

    function automatic void filt_step(input bit vis, inout bit f, inout int strk);
        if (vis != f) begin
            strk++;
            if (strk >= FL) begin
                f    = vis;
                strk = 0;
            end
        end else begin
            strk = 0;
        end
    endfunction

    function automatic void model_step();
        bit pf, pt, pv, vl, vr;
        int nxt;
        if (!reset_n) begin
            hist_l   = {1'b0, 1'b0};
            hist_r   = {1'b0, 1'b0};
            m_fl     = 0;
            m_fr     = 0;
            m_strk_l = 0;
            m_strk_r = 0;
            m_state  = 0;
            m_dwell  = 0;
            m_cnt    = 0;
            m_dfwd   = 0;
            m_dturn  = 0;
            m_md     = 4'b0000;
            return;
        end
        pf = (m_cnt < m_dfwd);
        pt = (m_cnt < m_dturn);
        pv = bus.pivot;
        // md vector is {md1, md2, md3, md4}
        case (m_state)
            1:       m_md = {pf, 1'b0, pf, 1'b0};
            2:       m_md = {1'b0, pt & pv, pt, 1'b0};
            3:       m_md = {pt, 1'b0, 1'b0, pt & pv};
            5:       m_md = {1'b0, pt, 1'b0, pt};
            default: m_md = 4'b0000;
        endcase
        nxt = decide(m_fl, m_fr);
        if (!bus.run) begin
            m_state = 0;
            m_dwell = 0;
        end else if (m_state == 4 && m_fl && m_fr) begin
            if (m_dwell + 1 >= HOLD) begin
                m_state = 5;
                m_dwell = 0;
            end else begin
                m_dwell++;
            end
        end else if (m_state == 5) begin
            if (m_dwell + 1 >= BACK) begin
                m_state = nxt;
                m_dwell = 0;
            end else begin
                m_dwell++;
            end
        end else begin
            m_state = nxt;
            m_dwell = 0;
        end
        // Filter sees the pin level from two edges earlier.
        vl = hist_l[hist_l.size() - 2];
        vr = hist_r[hist_r.size() - 2];
        hist_l.push_back(bus.infL);
        hist_r.push_back(bus.infR);
        if (hist_l.size() > 3) void'(hist_l.pop_front());
        if (hist_r.size() > 3) void'(hist_r.pop_front());
        filt_step(vl, m_fl, m_strk_l);
        filt_step(vr, m_fr, m_strk_r);
        if (m_cnt == PER - 1) begin
            m_dfwd  = int'(bus.speed_fwd);
            m_dturn = int'(bus.speed_turn);
        end
        m_cnt = (m_cnt + 1) % PER;
    endfunction

    function automatic logic [3:0] md_vec();
        return {bus.md1, bus.md2, bus.md3, bus.md4};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("model_state", int'(bus.state), m_state);
        check("model_md", int'(md_vec()), int'(m_md));
        check("hbridge_shoot", int'((bus.md1 & bus.md2) | (bus.md3 & bus.md4)), 0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        check("reset_state", int'(bus.state), 0);
        check("reset_md", int'(md_vec()), 0);
        reset_n = 1'b1;
    endtask

    task automatic set_sens(input bit l, input bit r);
        bus.infL = l;
        bus.infR = r;
    endtask

    task automatic wait_state(input string name, input int code, input int limit);
        int n = 0;
        while (int'(bus.state) != code && n < limit) begin
            tick();
            n++;
        end
        check(name, int'(bus.state), code);
    endtask

    // Counts consecutive observations of a state, starting with the current one.
    task automatic run_len(input int code, input int limit, output int len);
        len = 0;
        while (int'(bus.state) == code && len < limit) begin
            len++;
            tick();
        end
    endtask

    typedef struct {
        bit l;
        bit r;
        bit run;
        bit pivot;
        int cycles;
        int exp_state;
    } vec_t;

    vec_t vecs[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int h1, h2, hx, len;
        reset_n        = 1'b0;
        bus.infL       = 1'b0;
        bus.infR       = 1'b0;
        bus.run        = 1'b0;
        bus.pivot      = 1'b0;
        bus.speed_fwd  = 4'd4;
        bus.speed_turn = 4'd6;

        vecs = '{
            '{0, 0, 1, 0, 8, 1},
            '{1, 0, 1, 0, 8, 2},
            '{0, 1, 1, 0, 8, 3},
            '{0, 0, 0, 0, 8, 0},
            '{0, 0, 1, 0, 2, 1},
            '{1, 1, 1, 0, 6, 4},
            '{1, 1, 1, 0, 8, 5},
            '{1, 1, 1, 0, 4, 4},
            '{0, 0, 1, 0, 6, 1},
            '{1, 0, 1, 0, 2, 1},
            '{0, 0, 1, 0, 6, 1},
            '{1, 0, 1, 1, 8, 2},
            '{0, 1, 1, 1, 8, 3}
        };

        do_reset();
        foreach (vecs[i]) begin
            set_sens(vecs[i].l, vecs[i].r);
            bus.run   = vecs[i].run;
            bus.pivot = vecs[i].pivot;
            repeat (vecs[i].cycles) tick();
            check($sformatf("vec%0d_state", i), int'(bus.state), vecs[i].exp_state);
        end

        // FWD drive at duty 4.
        do_reset();
        bus.run = 1'b1;
        set_sens(0, 0);
        bus.pivot = 1'b0;
        tick();
        check("fwd_entry", int'(bus.state), 1);
        repeat (32) tick();
        h1 = 0; h2 = 0; hx = 0;
        repeat (PER) begin
            tick();
            h1 += int'(bus.md1);
            h2 += int'(bus.md3);
            hx += int'(bus.md2 | bus.md4);
        end
        check("fwd_md1_high", h1, 4);
        check("fwd_md3_high", h2, 4);
        check("fwd_rev_high", hx, 0);

        // Short left glitch rejected, then held level reaches LEFT at edge 6.
        bus.infL = 1'b1;
        tick();
        tick();
        bus.infL = 1'b0;
        repeat (10) tick();
        check("glitch_reject", int'(bus.state), 1);
        bus.infL = 1'b1;
        repeat (5) tick();
        check("left_edge5", int'(bus.state), 1);
        tick();
        check("left_edge6", int'(bus.state), 2);
        tick();
        check("left_edge7_md12", int'({bus.md1, bus.md2}), 0);
        h1 = 0; hx = 0;
        repeat (PER) begin
            tick();
            h1 += int'(bus.md3);
            hx += int'(bus.md1 | bus.md2);
        end
        check("swing_md3_high", h1, 6);
        check("swing_left_off", hx, 0);
        bus.pivot = 1'b1;
        tick();
        h1 = 0; hx = 0;
        repeat (PER) begin
            tick();
            h1 += int'(bus.md2);
            hx += int'(bus.md2 != bus.md3);
        end
        check("pivot_md2_high", h1, 6);
        check("pivot_md2_eq_md3", hx, 0);

        // STOP hold then BACK.
        bus.pivot = 1'b0;
        bus.infR  = 1'b1;
        repeat (5) tick();
        check("stop_edge5", int'(bus.state), 2);
        tick();
        check("stop_entry", int'(bus.state), 4);
        tick();
        check("stop_md", int'(md_vec()), 0);
        run_len(4, 50, len);
        check("stop_len", len + 1, HOLD);
        check("back_entry", int'(bus.state), 5);
        run_len(5, 50, len);
        check("back_len", len, BACK);
        check("back_to_stop", int'(bus.state), 4);

        // Duty change mid-period.
        do_reset();
        bus.run       = 1'b1;
        bus.speed_fwd = 4'd4;
        set_sens(0, 0);
        repeat (40) tick();
        len = 0;
        while (m_cnt != 0 && len < 2 * PER) begin
            tick();
            len++;
        end
        h1 = 0;
        repeat (5) begin
            tick();
            h1 += int'(bus.md1);
        end
        bus.speed_fwd = 4'd12;
        repeat (11) begin
            tick();
            h1 += int'(bus.md1);
        end
        check("duty_old_period", h1, 4);
        h2 = 0;
        repeat (PER) begin
            tick();
            h2 += int'(bus.md1);
        end
        check("duty_new_period", h2, 12);

        // run dropped mid-BACK.
        set_sens(1, 1);
        wait_state("reach_back", 5, 40);
        tick();
        bus.run = 1'b0;
        tick();
        check("run_off_state", int'(bus.state), 0);
        tick();
        check("run_off_md", int'(md_vec()), 0);
        set_sens(0, 0);
        repeat (8) tick();
        bus.run = 1'b1;
        tick();
        check("run_on_fwd", int'(bus.state), 1);
        repeat (4) tick();
        set_sens(1, 1);
        repeat (6) tick();
        check("restop_entry", int'(bus.state), 4);
        run_len(4, 50, len);
        check("restop_len", len, HOLD);

        // Reset during RIGHT pivot.
        set_sens(0, 1);
        bus.pivot = 1'b1;
        repeat (20) tick();
        check("right_pivot", int'(bus.state), 3);
        reset_n = 1'b0;
        tick();
        check("midrun_reset_state", int'(bus.state), 0);
        check("midrun_reset_md", int'(md_vec()), 0);
        reset_n = 1'b1;
        tick();
        check("post_reset_fwd", int'(bus.state), 1);
        repeat (4) tick();
        check("post_reset_edge5", int'(bus.state), 1);
        tick();
        check("post_reset_edge6", int'(bus.state), 3);

        // Randomised run against the model (checked inside tick).
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 19) == 0) begin
                bus.infL = 1'($urandom_range(0, 1));
                bus.infR = 1'($urandom_range(0, 1));
            end
            if (bus.run) begin
                if ($urandom_range(0, 149) == 0) bus.run = 1'b0;
            end else if ($urandom_range(0, 9) == 0) begin
                bus.run = 1'b1;
            end
            if ($urandom_range(0, 29) == 0) bus.pivot = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 39) == 0) bus.speed_fwd = 4'($urandom);
            if ($urandom_range(0, 39) == 0) bus.speed_turn = 4'($urandom);
            reset_n = ($urandom_range(0, 599) != 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
